mag_window_stats: RTL

- Streaming statistics stage directly downstream of the 16-bit absolute-value unit; consumes its unsigned magnitude output.
- Collects windows of 2^WIN_LOG2 accepted samples and emits, per window, the peak magnitude and the exact magnitude sum.
- Valid/ready on both sides; a one-deep result register sits on the output.

---
 rtl/mag_window_stats_if.sv | 25 ++
 rtl/mag_window_stats.sv | 96 +++++++++
 2 files changed

// File: rtl/mag_window_stats_if.sv
// Valid/ready bundle between the magnitude source, the window statistics stage and its consumer.
// Carries the synchronous flush alongside the data handshakes.
interface mag_window_stats_if #(
    parameter int N        = 16,
    parameter int WIN_LOG2 = 4
);
    logic                  clr;
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          in_mag;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          out_peak;
    logic [N+WIN_LOG2-1:0] out_sum;

    modport master (
        output clr, in_valid, in_mag, out_ready,
        input  in_ready, out_valid, out_peak, out_sum
    );

    modport slave (
        input  clr, in_valid, in_mag, out_ready,
        output in_ready, out_valid, out_peak, out_sum
    );
endinterface

// File: rtl/mag_window_stats.sv
// Per-window peak and exact sum of unsigned magnitudes over 2^WIN_LOG2 accepted samples.
// State | meaning:  ACCUM | collecting samples, in_ready=1;  HOLD | result pending, out_valid=1
module mag_window_stats #(
    parameter int N        = 16,
    parameter int WIN_LOG2 = 4
) (
    input logic clk,
    input logic rst_n,
    mag_window_stats_if.slave bus
);
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam int SW = N + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
    localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);

    state_t              state_q, state_d;
    logic [WIN_LOG2-1:0] cnt;
    logic [N-1:0]        peak_acc;
    logic [SW-1:0]       sum_acc;
    logic [N-1:0]        peak_reg;
    logic [SW-1:0]       sum_reg;
    logic                accept;
    logic                last;
    logic [N-1:0]        peak_next;
    logic [SW-1:0]       sum_next;

    assign last      = (cnt == CNT_LAST);
    assign peak_next = (bus.in_mag > peak_acc) ? bus.in_mag : peak_acc;
    assign sum_next  = sum_acc + {{WIN_LOG2{1'b0}}, bus.in_mag};

    // Handshake flags come from the registered state only.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_peak  = peak_reg;
    assign bus.out_sum   = sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (bus.clr) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        accept = 1'b1;
                        if (last) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            peak_acc <= '0;
            sum_acc  <= '0;
            peak_reg <= '0;
            sum_reg  <= '0;
        end else if (bus.clr) begin
            cnt      <= '0;
            peak_acc <= '0;
            sum_acc  <= '0;
        end else if (accept) begin
            if (last) begin
                peak_reg <= peak_next;
                sum_reg  <= sum_next;
                cnt      <= '0;
                peak_acc <= '0;
                sum_acc  <= '0;
            end else begin
                peak_acc <= peak_next;
                sum_acc  <= sum_next;
                cnt      <= cnt + CNT_ONE;
            end
        end
    end
endmodule
